// File: rtl/sw_pkg.sv
// Shared definitions for the switch conditioning slice.
//   SW_WIDTH        default number of switch bits
//   SW_CNT_MAX_DEF  default hold time in clk cycles (1 ms @ 100 MHz)
//   bit_state_t     per-bit debounce FSM state
package sw_pkg;

  localparam int unsigned SW_WIDTH       = 4;
  localparam int unsigned SW_CNT_MAX_DEF = 100000;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } bit_state_t;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchroniser + debouncer.
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   d_raw  raw asynchronous switch level
//   q_db   debounced level
//   upd    1-cycle pulse, high in the cycle q_db shows a new value
// A new level must be seen for CNT_MAX+1 consecutive cycles at the
// synchroniser output before q_db takes it; any bounce back restarts.
module debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned CNT_MAX = SW_CNT_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic q_db,
  output logic upd
);

  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  if (CNT_MAX < 1) begin : g_bad_cnt_max
    $error("debounce_bit: CNT_MAX must be >= 1");
  end

  logic          s1, s2;
  bit_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          q_nx, upd_nx;

  // Plain two-flop synchroniser, nothing between the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d_raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_STABLE;
      cnt   <= '0;
      q_db  <= 1'b0;
      upd   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      q_db  <= q_nx;
      upd   <= upd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    q_nx     = q_db;
    upd_nx   = 1'b0;
    case (state)
      ST_STABLE: begin
        if (s2 != q_db) begin
          state_nx = ST_COUNT;
          cnt_nx   = CW'(1);
        end else begin
          cnt_nx   = '0;
        end
      end
      ST_COUNT: begin
        if (s2 == q_db) begin
          state_nx = ST_STABLE;
          cnt_nx   = '0;
        end else if (cnt == CW'(CNT_MAX)) begin
          state_nx = ST_STABLE;
          cnt_nx   = '0;
          q_nx     = s2;
          upd_nx   = 1'b1;
        end else begin
          cnt_nx   = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = ST_STABLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning stage ahead of the 4-to-2 encoder: synchronises and
// debounces each raw switch bit independently.
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   sw       raw asynchronous switch inputs
//   sw_db    debounced switch levels (feed encoder sw)
//   changed  1-cycle pulse aligned with any new sw_db value
//   rise     per-bit 1-cycle 0->1 pulse, aligned with changed
//            (present only when SW_EDGE_OUT_EN is defined)
module sw_debounce
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH   = SW_WIDTH,
  parameter int unsigned CNT_MAX = SW_CNT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_db,
  output logic             changed
`ifdef SW_EDGE_OUT_EN
  ,
  output logic [WIDTH-1:0] rise
`endif
);

  logic [WIDTH-1:0] upd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .CNT_MAX(CNT_MAX)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .d_raw(sw[i]),
      .q_db (sw_db[i]),
      .upd  (upd[i])
    );
  end

  // upd bits are registered, so changed is glitch-free and one pulse
  // covers every bit that updated on the same edge.
  assign changed = |upd;

`ifdef SW_EDGE_OUT_EN
  // A bit that just updated to 1 was necessarily a 0->1 transition.
  assign rise = upd & sw_db;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

  localparam int unsigned W  = 4;
  localparam int unsigned CM = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw  = '1;
  logic [W-1:0] sw_db;
  logic         changed;
`ifdef SW_EDGE_OUT_EN
  logic [W-1:0] rise;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  sw_debounce #(
    .WIDTH  (W),
    .CNT_MAX(CM)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .sw_db  (sw_db),
    .changed(changed)
`ifdef SW_EDGE_OUT_EN
    ,
    .rise   (rise)
`endif
  );

  always #5 clk = ~clk;

  // Reference: sw seen by the debouncer two edges late; a bit flips once
  // its late view has differed from the output for CM+1 edges in a row.
  logic [W-1:0] m_p0, m_p1, m_db, m_rise;
  logic         m_chg;
  int           m_run [W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p0 = '0; m_p1 = '0; m_db = '0; m_rise = '0; m_chg = 1'b0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      m_chg  = 1'b0;
      m_rise = '0;
      for (int i = 0; i < W; i++) begin
        if (m_p1[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == CM + 1) begin
            m_db[i]  = m_p1[i];
            m_run[i] = 0;
            m_chg    = 1'b1;
            m_rise[i] = m_db[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_p1 = m_p0;
      m_p0 = sw;
    end
  endtask

  task automatic check_outputs();
    check("sw_db", 32'(sw_db), 32'(m_db));
    check("changed", 32'(changed), 32'(m_chg));
`ifdef SW_EDGE_OUT_EN
    check("rise", 32'(rise), 32'(m_rise));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic settle(input logic [W-1:0] v);
    sw = v;
    repeat (12) tick();
  endtask

  // Apply v right after an edge; the next edge is the sampling edge.
  task automatic wait_db(input string tag, input logic [W-1:0] target, input int exp_n);
    int n = 0;
    int pulses = 0;
    bit hit = 0;
    while (n < 20 && !hit) begin
      tick();
      n++;
      pulses += int'(changed);
      if (sw_db === target) hit = 1;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_n));
    repeat (5) begin
      tick();
      pulses += int'(changed);
    end
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
  endtask

  task automatic rst_pulse(input int edges);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    repeat (edges) tick();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    // 1: reset with all switches high, then requalify
    repeat (4) tick();
    rst = 1'b0;
    wait_db("reset_release", 4'b1111, CM + 3);
    settle(4'b0000);

    // 2: clean step
    sw = 4'b0001;
    wait_db("step", 4'b0001, CM + 3);
    settle(4'b0000);

    // 3: bounce on bit 1
    for (int k = 0; k < 4; k++) begin
      sw = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      repeat (2) tick();
      check("bounce_hold", 32'(sw_db[1]), 32'd0);
    end
    sw = 4'b0010;
    wait_db("bounce", 4'b0010, CM + 3);
    settle(4'b0000);

    // 4: parallel
    sw = 4'b1010;
    wait_db("parallel", 4'b1010, CM + 3);
    settle(4'b0000);

    // 5: walking one
    for (int k = 0; k < W; k++) begin
      sw = 4'(1 << k);
      repeat (10) begin
        tick();
        check("walk_onehot", 32'($countones(sw_db) <= 1), 32'd1);
      end
    end
    settle(4'b0000);

    // 6: reset mid-count
    sw = 4'b0100;
    repeat (3) tick();
    rst_pulse(2);
    check("midrst_db", 32'(sw_db), 32'd0);
    wait_db("midrst", 4'b0100, CM + 3);

    // Random hold lengths, occasional reset
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(39) == 0) rst_pulse(int'($urandom_range(3)));
      sw = 4'($urandom);
      repeat ($urandom_range(8, 1)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
